// File: rtl/aes_output_arbiter_pkg.sv
// Shared types for the AES output arbiter: FSM state encoding and grant helper.
package aes_output_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_HOLD0 = 2'd1,
        ARB_HOLD1 = 2'd2
    } arb_state_e;

    // Hold state that grants the given source index.
    function automatic arb_state_e hold_state(input logic src);
        return src ? ARB_HOLD1 : ARB_HOLD0;
    endfunction

endpackage

// File: rtl/aes_output_arbiter_out_reg.sv
// aes_arb_out_reg: single-entry registered output stage. Holds one beat
// stable while the FIFO stalls and passes readiness back to the arbiter.
module aes_arb_out_reg #(
    parameter int WIDTH = 129
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Room for a new beat when empty or when the held beat drains this cycle.
    assign in_ready = !valid_q || m_tready;

    // Next-state of the holding register: load on accept, clear on drain.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (m_tready) begin
            valid_d = 1'b0;
        end
    end

    // Holding register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            valid_q <= 1'b0;
            // NOTE: the data register is reset as well, so m_tdata reads 0 straight out of reset.
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign m_tvalid = valid_q;
    assign m_tdata  = data_q;

endmodule

// File: rtl/aes_output_arbiter.sv
// aes_output_arbiter: packet-atomic round-robin arbiter sharing the output
// FIFO write port between the AES core path (s0) and the pass-through path (s1).
// Optional per-source packet and conflict counters under AES_ARB_STATS_EN.
module aes_output_arbiter
    import aes_output_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 128
`ifdef AES_ARB_STATS_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s0_tvalid,
    output logic                  s0_tready,
    input  logic [DATA_WIDTH:0]   s0_tdata,
    input  logic                  s1_tvalid,
    output logic                  s1_tready,
    input  logic [DATA_WIDTH:0]   s1_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH:0]   m_tdata,
    output logic                  busy
`ifdef AES_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  s0_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  s1_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
`endif
);

    arb_state_e          state_q, state_d;
    logic                rr_q, rr_d;
    logic                sel_valid;
    logic [DATA_WIDTH:0] sel_data;
    logic                out_ready;
    logic                accept_last;

    // Route the granted source towards the output stage; nothing moves in IDLE.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = s0_tdata;
        case (state_q)
            ARB_HOLD0: begin
                sel_valid = s0_tvalid;
                sel_data  = s0_tdata;
            end
            ARB_HOLD1: begin
                sel_valid = s1_tvalid;
                sel_data  = s1_tdata;
            end
            default: ;
        endcase
    end

    assign s0_tready   = (state_q == ARB_HOLD0) && out_ready;
    assign s1_tready   = (state_q == ARB_HOLD1) && out_ready;
    assign accept_last = sel_valid && out_ready && sel_data[DATA_WIDTH];
    assign busy        = (state_q != ARB_IDLE) || m_tvalid;

    aes_arb_out_reg #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_out_reg (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (sel_valid),
        .in_data  (sel_data),
        .in_ready (out_ready),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata)
    );

    // Grant decision in IDLE; release and rotate priority after a last beat.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            ARB_IDLE: begin
                if (s0_tvalid && s1_tvalid) state_d = hold_state(rr_q);
                else if (s0_tvalid)         state_d = ARB_HOLD0;
                else if (s1_tvalid)         state_d = ARB_HOLD1;
            end
            ARB_HOLD0: begin
                if (accept_last) begin
                    state_d = ARB_IDLE;
                    rr_d    = 1'b1;
                end
            end
            ARB_HOLD1: begin
                if (accept_last) begin
                    state_d = ARB_IDLE;
                    rr_d    = 1'b0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Arbitration state and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

`ifdef AES_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] s0_cnt_q, s0_cnt_d;
    logic [CNT_WIDTH-1:0] s1_cnt_q, s1_cnt_d;
    logic [CNT_WIDTH-1:0] cfl_cnt_q, cfl_cnt_d;

    // Count completed packets per source and IDLE cycles with both requesting.
    always_comb begin
        s0_cnt_d  = s0_cnt_q;
        s1_cnt_d  = s1_cnt_q;
        cfl_cnt_d = cfl_cnt_q;
        if (accept_last && state_q == ARB_HOLD0) s0_cnt_d = s0_cnt_q + 1'b1;
        if (accept_last && state_q == ARB_HOLD1) s1_cnt_d = s1_cnt_q + 1'b1;
        if (state_q == ARB_IDLE && s0_tvalid && s1_tvalid) cfl_cnt_d = cfl_cnt_q + 1'b1;
    end

    // Statistics counters, wrapping naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s0_cnt_q  <= '0;
            s1_cnt_q  <= '0;
            cfl_cnt_q <= '0;
        end else begin
            s0_cnt_q  <= s0_cnt_d;
            s1_cnt_q  <= s1_cnt_d;
            cfl_cnt_q <= cfl_cnt_d;
        end
    end

    assign s0_pkt_cnt   = s0_cnt_q;
    assign s1_pkt_cnt   = s1_cnt_q;
    assign conflict_cnt = cfl_cnt_q;
`endif

endmodule

// File: tb/tb_aes_output_arbiter.sv
// Testbench for aes_output_arbiter. Directed timing scenarios plus randomized
// traffic scored against a packet-level model. Statistics checks are compiled
// in when AES_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module tb_aes_output_arbiter;

    localparam int DW = 128;
    typedef logic [DW:0] beat_t;

    logic  clk = 1'b0;
    always #5 clk = ~clk;

    logic  resetn;
    logic  s0_tvalid, s0_tready, s1_tvalid, s1_tready;
    logic  m_tvalid, m_tready, busy;
    beat_t s0_tdata, s1_tdata, m_tdata;
`ifdef AES_ARB_STATS_EN
    localparam int CW = 2;
    logic [CW-1:0] s0_pkt_cnt, s1_pkt_cnt, conflict_cnt;
`endif

    aes_output_arbiter #(
        .DATA_WIDTH (DW)
`ifdef AES_ARB_STATS_EN
        ,
        .CNT_WIDTH  (CW)
`endif
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .s0_tvalid    (s0_tvalid),
        .s0_tready    (s0_tready),
        .s0_tdata     (s0_tdata),
        .s1_tvalid    (s1_tvalid),
        .s1_tready    (s1_tready),
        .s1_tdata     (s1_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .busy         (busy)
`ifdef AES_ARB_STATS_EN
        ,
        .s0_pkt_cnt   (s0_pkt_cnt),
        .s1_pkt_cnt   (s1_pkt_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t q0[$], q1[$];          // beats still to be offered by each source
    beat_t exp_out[$];            // expected output beats in order
    int    exp_cyc[$];            // expected cycle each beat drains
    beat_t out_data[$];
    int    out_cyc[$];
    int    cyc, exp_t;
    int    start0, start1, gap_lo1, gap_hi1, vpct, rpct, stall_lo, stall_hi;
    int    first_rdy0;
    bit    acc0, acc1, prev_stall;
    beat_t prev_data;

    task automatic check(input string tag, input beat_t obs, input beat_t exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Beat tagged with source/packet/index so the scoreboard can identify it.
    function automatic beat_t mk_beat(int src, int pkt, int idx, bit last);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return {last, 8'(src + 1), 8'(pkt), 8'(idx), r[103:0]};
    endfunction

    // Expected timeline with m_tready held high: contiguous beats, one bubble between packets.
    task automatic expect_pkt(input beat_t beats[$]);
        foreach (beats[i]) begin
            exp_out.push_back(beats[i]);
            exp_cyc.push_back(exp_t);
            exp_t++;
        end
        exp_t++;
    endtask

    task automatic setup();
        cyc = 0; exp_t = 2; first_rdy0 = -1;
        start0 = 0; start1 = 0; gap_lo1 = 0; gap_hi1 = 0;
        vpct = 100; rpct = 100; stall_lo = 0; stall_hi = 0;
        out_data.delete(); out_cyc.delete(); exp_out.delete(); exp_cyc.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0; s0_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b0;
        s0_tdata = '0; s1_tdata = '0;
        q0.delete(); q1.delete(); acc0 = 1'b0; acc1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Source valid stays up until accepted (AXI-Stream), otherwise may rise when permitted.
    task automatic drive();
        bit ok1;
        if (q0.size() > 0 && ((s0_tvalid && !acc0) ||
            (cyc >= start0 && $urandom_range(99) < vpct))) begin
            s0_tvalid = 1'b1; s0_tdata = q0[0];
        end else s0_tvalid = 1'b0;
        ok1 = cyc >= start1 && !(cyc >= gap_lo1 && cyc < gap_hi1);
        if (q1.size() > 0 && ((s1_tvalid && !acc1) ||
            (ok1 && $urandom_range(99) < vpct))) begin
            s1_tvalid = 1'b1; s1_tdata = q1[0];
        end else s1_tvalid = 1'b0;
        if (cyc >= stall_lo && cyc < stall_hi) m_tready = 1'b0;
        else m_tready = ($urandom_range(99) < rpct);
    endtask

    // One clock: drive, observe handshakes before the edge, apply them after.
    task automatic tick();
        drive();
        #3;
        check("grant_excl", beat_t'(s0_tready & s1_tready), beat_t'(0));
        if (m_tvalid && !m_tready)
            check("stall_ready", beat_t'(s0_tready | s1_tready), beat_t'(0));
        if (s0_tready && first_rdy0 < 0) first_rdy0 = cyc;
        acc0 = s0_tvalid && s0_tready;
        acc1 = s1_tvalid && s1_tready;
        if (m_tvalid && m_tready) begin
            out_data.push_back(m_tdata);
            out_cyc.push_back(cyc);
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        @(posedge clk);
        #1;
        cyc++;
        if (acc0) void'(q0.pop_front());
        if (acc1) void'(q1.pop_front());
        if (prev_stall) begin
            check("stall_hold_v", beat_t'(m_tvalid), beat_t'(1));
            check("stall_hold_d", m_tdata, prev_data);
        end
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_count"}, beat_t'(out_data.size()), beat_t'(exp_out.size()));
        for (int i = 0; i < exp_out.size(); i++) begin
            if (i < out_data.size()) begin
                check($sformatf("%s_data%0d", tag, i), out_data[i], exp_out[i]);
                check($sformatf("%s_cyc%0d", tag, i), beat_t'(out_cyc[i]), beat_t'(exp_cyc[i]));
            end
        end
    endtask

    // Random traffic: output must be whole packets, each source's beats in order.
    task automatic random_run(input int np, input int vp, input int rp);
        beat_t e0[$], e1[$];
        beat_t b;
        int    len, src, cur_src, total, budget;
        bit    in_pkt;
        do_reset();
        setup();
        vpct = vp; rpct = rp;
        total = 0;
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < np; p++) begin
                len = $urandom_range(4, 1);
                for (int i = 0; i < len; i++) begin
                    b = mk_beat(s, p, i, i == len - 1);
                    total++;
                    if (s == 0) begin q0.push_back(b); e0.push_back(b); end
                    else        begin q1.push_back(b); e1.push_back(b); end
                end
            end
        end
        budget = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_tvalid) && budget < 4000) begin
            tick();
            budget++;
        end
        check("rnd_drained", beat_t'(q0.size() + q1.size()), beat_t'(0));
        check("rnd_count", beat_t'(out_data.size()), beat_t'(total));
        in_pkt = 1'b0; cur_src = 0;
        foreach (out_data[i]) begin
            src = int'(out_data[i][DW-1 -: 8]) - 1;
            if (in_pkt) check($sformatf("rnd_interleave%0d", i), beat_t'(src), beat_t'(cur_src));
            cur_src = src;
            in_pkt  = !out_data[i][DW];
            if (src == 0 && e0.size() > 0)
                check($sformatf("rnd_s0_beat%0d", i), out_data[i], e0.pop_front());
            else if (src == 1 && e1.size() > 0)
                check($sformatf("rnd_s1_beat%0d", i), out_data[i], e1.pop_front());
        end
        check("rnd_left", beat_t'(e0.size() + e1.size()), beat_t'(0));
    endtask

    initial begin
        beat_t pk[$];
        beat_t b1, b2;

        // Reset state
        do_reset();
        setup();
        #3;
        check("rst_m_tvalid", beat_t'(m_tvalid), beat_t'(0));
        check("rst_m_tdata", m_tdata, beat_t'(0));
        check("rst_s0_tready", beat_t'(s0_tready), beat_t'(0));
        check("rst_s1_tready", beat_t'(s1_tready), beat_t'(0));
        check("rst_busy", beat_t'(busy), beat_t'(0));
        @(posedge clk);
        #1;

        // Basic 3-block s0 packet
        setup();
        pk = '{{1'b0, 128'h01}, {1'b0, 128'h02}, {1'b1, 128'h03}};
        q0 = pk;
        expect_pkt(pk);
        repeat (8) tick();
        compare_out("basic");
        check("basic_state", beat_t'(dut.state_q), beat_t'(0));
        check("basic_rr", beat_t'(dut.rr_q), beat_t'(1));

        // Round-robin with both sources continuously valid (start from rr=0)
        do_reset();
        setup();
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 2; s++) begin
                pk = '{mk_beat(s, p, 0, 1'b0), mk_beat(s, p, 1, 1'b1)};
                if (s == 0) foreach (pk[i]) q0.push_back(pk[i]);
                else        foreach (pk[i]) q1.push_back(pk[i]);
                expect_pkt(pk);
            end
        end
        repeat (16) tick();
        compare_out("rr");

        // Backpressure: FIFO stalls for 5 cycles while beat 2 is held
        setup();
        for (int i = 0; i < 4; i++) q1.push_back(mk_beat(1, 9, i, i == 3));
        exp_out = q1;
        stall_lo = 3; stall_hi = 8;
        exp_cyc = '{2, stall_hi, stall_hi + 1, stall_hi + 2};
        repeat (14) tick();
        compare_out("bp");

        // Mid-packet contention: s1 pauses mid-packet while s0 waits
        setup();
        for (int i = 0; i < 3; i++) q1.push_back(mk_beat(1, 3, i, i == 2));
        q0.push_back(mk_beat(0, 4, 0, 1'b1));
        exp_out = q1;
        exp_out.push_back(q0[0]);
        start0 = 2; gap_lo1 = 2; gap_hi1 = 6;
        exp_cyc = '{2, gap_hi1 + 1, gap_hi1 + 2, gap_hi1 + 4};
        repeat (14) tick();
        compare_out("cont");
        check("cont_s0_grant", beat_t'(first_rdy0), beat_t'(gap_hi1 + 3));
        check("cont_state", beat_t'(dut.state_q), beat_t'(0));

        // Reset mid-packet discards the held beat
        b1 = mk_beat(0, 7, 0, 1'b0);
        b2 = mk_beat(0, 7, 1, 1'b1);
        s0_tvalid = 1'b1; s0_tdata = b1; s1_tvalid = 1'b0; m_tready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mrst_pre_v", beat_t'(m_tvalid), beat_t'(1));
        check("mrst_pre_d", m_tdata, b1);
        check("mrst_pre_rr", beat_t'(dut.rr_q), beat_t'(1));
        s0_tdata = b2; resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1; s0_tvalid = 1'b0;
        #3;
        check("mrst_m_tvalid", beat_t'(m_tvalid), beat_t'(0));
        check("mrst_m_tdata", m_tdata, beat_t'(0));
        check("mrst_state", beat_t'(dut.state_q), beat_t'(0));
        check("mrst_rr", beat_t'(dut.rr_q), beat_t'(0));
        check("mrst_busy", beat_t'(busy), beat_t'(0));
        @(posedge clk); #1;
        check("mrst_still_idle", beat_t'(m_tvalid), beat_t'(0));

        // Randomized traffic against the packet scoreboard
        random_run(6, 70, 100);
        random_run(6, 50, 40);

`ifdef AES_ARB_STATS_EN
        // Statistics: 3 s0 packets, 2 s1 packets, two IDLE conflicts, then wrap
        do_reset();
        setup();
        check("st_rst_s0", beat_t'(s0_pkt_cnt), beat_t'(0));
        for (int p = 0; p < 3; p++) q0.push_back(mk_beat(0, p, 0, 1'b1));
        for (int p = 0; p < 2; p++) q1.push_back(mk_beat(1, p, 0, 1'b1));
        start1 = 4;
        repeat (14) tick();
        check("st_s0", beat_t'(s0_pkt_cnt), beat_t'(3));
        check("st_s1", beat_t'(s1_pkt_cnt), beat_t'(2));
        check("st_conflict", beat_t'(conflict_cnt), beat_t'(2));
        q0.push_back(mk_beat(0, 5, 0, 1'b1));
        repeat (4) tick();
        check("st_s0_wrap", beat_t'(s0_pkt_cnt), beat_t'((3 + 1) % (1 << CW)));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
